// File: rtl/router_ni_pkg.sv
// Shared definitions for the router network-interface blocks: channel layout,
// flow-control layout and the buffered flit record.
package router_ni_pkg;

  localparam int FLIT_DATA_W = 64;
  localparam int CHANNEL_W   = 70;
  localparam int FC_W        = 3;
  localparam int NUM_VCS     = 4;
  localparam int VC_W        = 2;

  // Input channel bit positions (ascending numbering, bit 0 is the valid flag)
  localparam int CH_VALID    = 0;
  localparam int CH_VC_LO    = 1;
  localparam int CH_VC_HI    = 2;
  localparam int CH_HEAD     = 3;
  localparam int CH_TAIL     = 4;
  localparam int CH_RSVD     = 5;
  localparam int CH_DATA_LSB = 6;
  localparam int CH_DATA_MSB = 69;

  localparam int FC_VALID    = 0;
  localparam int FC_VC_LO    = 1;
  localparam int FC_VC_HI    = 2;

  typedef logic [VC_W-1:0] vc_t;

  typedef struct packed {
    logic                   head;
    logic                   tail;
    logic [0:FLIT_DATA_W-1] data;
  } flit_t;

endpackage

// File: rtl/ni_flit_fifo.sv
// Small synchronous flit FIFO with count-based full/empty flags; push and pop
// may happen in the same cycle.
module ni_flit_fifo
  import router_ni_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  flit_t wr_flit,
  output flit_t rd_flit,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_flit = mem[rd_ptr];

  // NOTE: the storage array has no reset; count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_flit;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_inject_ni.sv
// Injection network interface: buffers core flits, allocates a router VC per
// packet round-robin and sends one flit per cycle against per-VC credits.
module router_inject_ni
  import router_ni_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BUF_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_head,
  input  logic                   in_tail,
  input  logic [0:FLIT_DATA_W-1] in_data,
  output logic [0:CHANNEL_W-1]   channel_out,
  input  logic [0:FC_W-1]        flow_ctrl_in,
  output logic                   error
);

  localparam int CRED_W = $clog2(BUF_DEPTH + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]        state, state_next;
  vc_t               cur_vc, cur_vc_next;
  vc_t               rr, rr_next;
  logic [CRED_W-1:0] credit      [NUM_VCS];
  logic [CRED_W-1:0] credit_next [NUM_VCS];

  flit_t                rd_flit;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 send;
  logic                 drop;
  logic                 overflow;
  vc_t                  send_vc;
  vc_t                  pick;
  vc_t                  cand;
  logic                 found;
  logic                 fc_valid;
  vc_t                  fc_vc;
  logic [0:CHANNEL_W-1] channel_next;

  assign in_ready = !fifo_full;
  assign fc_valid = flow_ctrl_in[FC_VALID];
  assign fc_vc    = flow_ctrl_in[FC_VC_LO:FC_VC_HI];

  ni_flit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .pop     (pop),
    .wr_flit ('{head: in_head, tail: in_tail, data: in_data}),
    .rd_flit (rd_flit),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Round-robin pick: first VC holding credit, starting at rr.
  always_comb begin
    found = 1'b0;
    pick  = rr;
    cand  = rr;
    for (int k = 0; k < NUM_VCS; k++) begin
      cand = rr + VC_W'(k);
      if (!found && credit[cand] != '0) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_next  = state;
    cur_vc_next = cur_vc;
    rr_next     = rr;
    send        = 1'b0;
    drop        = 1'b0;
    send_vc     = cur_vc;
    if (!fifo_empty) begin
      case (state)
        IDLE: begin
          if (!rd_flit.head) begin
            drop = 1'b1;
          end else if (found) begin
            send    = 1'b1;
            send_vc = pick;
            rr_next = pick + 1'b1;
            if (!rd_flit.tail) begin
              state_next  = ACTIVE;
              cur_vc_next = pick;
            end
          end
        end
        default: begin
          if (rd_flit.head) begin
            drop = 1'b1;
          end else if (credit[cur_vc] != '0) begin
            send = 1'b1;
            if (rd_flit.tail) state_next = IDLE;
          end
        end
      endcase
    end
    pop = send || drop;
  end

  // Simultaneous send and return on one VC cancel out; a lone return at full credit is an error.
  always_comb begin
    overflow = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      credit_next[v] = credit[v];
      if (fc_valid && fc_vc == VC_W'(v) && !(send && send_vc == VC_W'(v))) begin
        if (credit[v] == CRED_W'(BUF_DEPTH)) overflow = 1'b1;
        else credit_next[v] = credit[v] + 1'b1;
      end else if (send && send_vc == VC_W'(v) && !(fc_valid && fc_vc == VC_W'(v))) begin
        credit_next[v] = credit[v] - 1'b1;
      end
    end
  end

  always_comb begin
    channel_next = '0;
    if (send) begin
      channel_next[CH_VALID]                = 1'b1;
      channel_next[CH_VC_LO:CH_VC_HI]       = send_vc;
      channel_next[CH_HEAD]                 = rd_flit.head;
      channel_next[CH_TAIL]                 = rd_flit.tail;
      channel_next[CH_DATA_LSB:CH_DATA_MSB] = rd_flit.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cur_vc      <= '0;
      rr          <= '0;
      channel_out <= '0;
      error       <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) credit[v] <= CRED_W'(BUF_DEPTH);
    end else begin
      state       <= state_next;
      cur_vc      <= cur_vc_next;
      rr          <= rr_next;
      channel_out <= channel_next;
      error       <= error || drop || overflow;
      for (int v = 0; v < NUM_VCS; v++) credit[v] <= credit_next[v];
    end
  end

endmodule

// File: tb/tb_router_inject_ni.sv
// Directed bench for router_inject_ni: a queue-based packet model checked every
// cycle, plus literal expectations for each scenario.
module tb_router_inject_ni;

  localparam int BUF = 8;
  localparam int FQ  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_head = 1'b0;
  logic        in_tail = 1'b0;
  logic [0:63] in_data = '0;
  logic [0:69] channel_out;
  logic [0:2]  flow_ctrl_in = '0;
  logic        error;

  router_inject_ni #(.FIFO_DEPTH(FQ), .BUF_DEPTH(BUF)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_head      (in_head),
    .in_tail      (in_tail),
    .in_data      (in_data),
    .channel_out  (channel_out),
    .flow_ctrl_in (flow_ctrl_in),
    .error        (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit check_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          head;
    bit          tail;
    logic [0:63] data;
  } mflit_t;

  mflit_t      mq[$];
  mflit_t      f;
  int          m_cred[4];
  bit          m_active;
  int          m_cur;
  int          m_rr;
  bit          m_err;
  logic [0:69] m_chan;
  bit          m_ready;
  int          sent_vc;
  bit          acc;
  int          c;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      for (int v = 0; v < 4; v++) m_cred[v] = BUF;
      m_active = 0; m_cur = 0; m_rr = 0; m_err = 0;
      m_chan = '0; m_ready = 1;
    end else begin
      acc     = in_valid && (mq.size() < FQ);
      sent_vc = -1;
      if (mq.size() > 0) begin
        f = mq[0];
        if (!m_active) begin
          if (f.head) begin
            for (int k = 0; k < 4; k++)
              if (sent_vc < 0 && m_cred[(m_rr + k) % 4] > 0) sent_vc = (m_rr + k) % 4;
            if (sent_vc >= 0) begin
              void'(mq.pop_front());
              if (!f.tail) begin m_active = 1; m_cur = sent_vc; end
              m_rr = (sent_vc + 1) % 4;
            end
          end else begin
            void'(mq.pop_front());
            m_err = 1;
          end
        end else if (f.head) begin
          void'(mq.pop_front());
          m_err = 1;
        end else if (m_cred[m_cur] > 0) begin
          sent_vc = m_cur;
          void'(mq.pop_front());
          if (f.tail) m_active = 0;
        end
      end
      for (int v = 0; v < 4; v++) begin
        c = m_cred[v] - ((sent_vc == v) ? 1 : 0)
                      + ((flow_ctrl_in[0] && int'(flow_ctrl_in[1:2]) == v) ? 1 : 0);
        if (c > BUF) begin c = BUF; m_err = 1; end
        m_cred[v] = c;
      end
      if (acc) mq.push_back('{head: in_head, tail: in_tail, data: in_data});
      m_chan  = (sent_vc >= 0) ? {1'b1, 2'(sent_vc), f.head, f.tail, 1'b0, f.data} : '0;
      m_ready = (mq.size() < FQ);
    end
  end

  // ---------------- per-cycle compare and channel log ----------------
  typedef struct {
    int          cyc;
    int          vc;
    bit          head;
    bit          tail;
    logic [0:63] data;
  } obs_t;

  obs_t log_q[$];

  always @(negedge clk) begin
    if (check_en) begin
      check("channel_out", channel_out, m_chan);
      check("in_ready", in_ready, m_ready);
      check("error", error, m_err);
      if (channel_out[0])
        log_q.push_back('{cyc: cyc, vc: int'(channel_out[1:2]), head: channel_out[3],
                          tail: channel_out[4], data: channel_out[6:69]});
    end
  end

  // ---------------- stimulus helpers (all start and end on a negedge) ----------------
  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; flow_ctrl_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    log_q.delete();
  endtask

  task automatic push(input bit h, input bit t, input logic [0:63] d, output int acc_cyc);
    int waited;
    waited = 0;
    in_valid = 1'b1; in_head = h; in_tail = t; in_data = d;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    acc_cyc = -1;
    if (!in_ready) begin
      check("push_timeout", 1, 0);
    end else begin
      @(posedge clk);
      #1 acc_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int a0, tmp, c_cyc;

  initial begin
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    reset = 1'b1;
    check("reset_channel", channel_out, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_error", error, 0);

    // 3-flit packet on VC0
    do_reset();
    push(1, 0, 64'hA, a0);
    push(0, 0, 64'hB, tmp);
    push(0, 1, 64'hC, tmp);
    wait_cyc(4);
    check("pkt3_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("pkt3_first_lat", log_q[0].cyc - a0, 1);
      check("pkt3_last_lat", log_q[2].cyc - a0, 3);
      check("pkt3_vc", {log_q[0].vc[1:0], log_q[1].vc[1:0], log_q[2].vc[1:0]}, 0);
      check("pkt3_heads", {log_q[0].head, log_q[1].head, log_q[2].head}, 3'b100);
      check("pkt3_tails", {log_q[0].tail, log_q[1].tail, log_q[2].tail}, 3'b001);
      check("pkt3_data2", log_q[2].data, 64'hC);
    end
    check("pkt3_credit0", dut.credit[0], 5);

    // two single-flit packets, round-robin
    do_reset();
    push(1, 1, 64'h11, tmp);
    push(1, 1, 64'h22, tmp);
    wait_cyc(4);
    check("rr_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("rr_vc_first", log_q[0].vc, 0);
      check("rr_vc_second", log_q[1].vc, 1);
    end
    check("rr_pointer", dut.rr, 2);

    // credit exhaustion on VC0, then one credit releases the 9th flit
    do_reset();
    push(1, 0, 64'h100, tmp);
    for (int i = 1; i < 8; i++) push(0, 0, 64'h100 + 64'(i), tmp);
    push(0, 1, 64'h108, tmp);
    wait_cyc(5);
    check("stall_count", log_q.size(), 8);
    check("stall_credit0", dut.credit[0], 0);
    flow_ctrl_in = 3'b1_00;
    @(posedge clk);
    #1 c_cyc = cyc;
    @(negedge clk);
    flow_ctrl_in = '0;
    wait_cyc(3);
    check("release_count", log_q.size(), 9);
    if (log_q.size() == 9) begin
      check("release_lat", log_q[8].cyc - c_cyc, 1);
      check("release_flit", {log_q[8].tail, log_q[8].data}, {1'b1, 64'h108});
    end

    // send and credit return on VC0 in the same cycle
    do_reset();
    push(1, 1, 64'h44, tmp);
    flow_ctrl_in = 3'b1_00;
    @(negedge clk);
    flow_ctrl_in = '0;
    wait_cyc(2);
    check("same_cycle_sent", log_q.size(), 1);
    check("same_cycle_credit0", dut.credit[0], 8);
    check("same_cycle_error", error, 0);

    // orphan body flit
    do_reset();
    push(0, 0, 64'h55, tmp);
    wait_cyc(3);
    check("orphan_error", error, 1);
    check("orphan_no_output", log_q.size(), 0);

    // credit overflow on VC2
    do_reset();
    flow_ctrl_in = 3'b1_10;
    @(negedge clk);
    flow_ctrl_in = '0;
    wait_cyc(2);
    check("ovf_error", error, 1);
    check("ovf_credit2", dut.credit[2], 8);

    // drain every VC, then fill the FIFO
    do_reset();
    for (int p = 0; p < 4; p++) begin
      push(1, 0, 64'h200 + 64'(p), tmp);
      for (int i = 0; i < 6; i++) push(0, 0, 64'h300 + 64'(i), tmp);
      push(0, 1, 64'h3FF, tmp);
    end
    wait_cyc(5);
    check("drain_count", log_q.size(), 32);
    for (int p = 0; p < 4; p++) push(1, 1, 64'h400 + 64'(p), tmp);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1; in_data = 64'h499;
    wait_cyc(3);
    check("full_hold_in_ready", in_ready, 0);
    in_valid = 1'b0;
    wait_cyc(2);
    check("full_no_output", log_q.size(), 32);
    check("full_error", error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
